// File: rtl/jt51_logenc.sv
// jt51_logenc: linear-to-log encoder, the inverse of the exponent table path.
// Converts a linear magnitude into a 12-bit attenuation {exp4, frac8} in 1/256-octave steps.
// The input is normalised to a 13-bit mantissa with the leading one at bit 12.
// An 8-step successive-approximation search then runs against a registered 256x13 exponent
// table, T[i] = round(8192 * 2^(-(i+1)/256)).
//
// Optional feature: define JT51_LOGENC_SIGN_EN to treat lin as two's complement.
// The sign is then reported on out_sign, and the most-negative input saturates.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cen                  clock enable; all state advances only when high
//   in_valid, in_ready   request handshake; in_ready is high only while idle
//   lin [IW-1:0]         linear input, registered at accept
//   out_valid, out_ready result handshake; the result is held until accepted
//   att [11:0]           {exp4, frac8} attenuation
//   out_zero             input magnitude was zero (att = 12'hfff)
//   out_sign             input sign (always 0 without JT51_LOGENC_SIGN_EN)
module jt51_logenc #(
  parameter int unsigned IW = 16  // 13..16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] lin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [11:0]   att,
  output logic          out_zero,
  output logic          out_sign
);

  // Integer square root, used only at elaboration to build the table.
  function automatic logic [63:0] isqrt(input logic [127:0] n);
    logic [127:0] rem, res, one;
    rem = n;
    res = '0;
    for (int k = 63; k >= 0; k--) begin
      one = 128'd1 << (2 * k);
      if (rem >= res + one) begin
        rem = rem - res - one;
        res = (res >> 1) + one;
      end else begin
        res = res >> 1;
      end
    end
    return res[63:0];
  endfunction

  // The table is built from 2^(-2^j/256) factors in Q60.
  // Each factor is obtained by repeated square roots of 0.5.
  // This needs no transcendental constants.
  function automatic logic [256*13-1:0] gen_tab();
    logic [256*13-1:0] tab;
    logic [7:0][63:0]  r;
    logic [127:0]      p, v;
    logic [8:0]        k;
    tab  = '0;
    r[7] = isqrt(128'd1 << 119);
    for (int j = 6; j >= 0; j--) r[j] = isqrt({64'd0, r[j+1]} << 60);
    for (int i = 0; i < 256; i++) begin
      k = 9'(i + 1);
      p = 128'd1 << 60;
      for (int j = 0; j < 8; j++) begin
        if (k[j]) p = (p * {64'd0, r[j]}) >> 60;
      end
      if (k[8]) p = 128'd1 << 59;
      v = ((p << 13) + (128'd1 << 59)) >> 60;
      tab[13*i +: 13] = v[12:0];
    end
    return tab;
  endfunction

  localparam logic [256*13-1:0] TAB = gen_tab();

  typedef enum logic [2:0] {StIdle, StNorm, StAddr, StCmp, StDone} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] mag_q, mag_d;
  logic          sign_q, sign_d;
  logic [12:0]   m_q, m_d;
  logic [3:0]    exp_q, exp_d;
  logic          zero_q, zero_d;
  logic [7:0]    idx_q, idx_d;
  logic [2:0]    b_q, b_d;
  logic          valid_q, valid_d;
  logic [11:0]   att_q, att_d;
  logic          ozero_q, ozero_d;
  logic          osign_q, osign_d;
  logic          rdy_q;
  logic [12:0]   t_q;

  logic [IW-1:0] lin_mag;
  logic          lin_sign;
  logic [3:0]    lz;
  logic [IW-1:0] norm;
  logic [7:0]    addr;

`ifdef JT51_LOGENC_SIGN_EN
  always_comb begin
    lin_sign = lin[IW-1];
    if (lin == {1'b1, {(IW-1){1'b0}}}) lin_mag = {1'b0, {(IW-1){1'b1}}};
    else if (lin_sign)                 lin_mag = -lin;
    else                               lin_mag = lin;
  end
`else
  assign lin_sign = 1'b0;
  assign lin_mag  = lin;
`endif

  // Leading-zero count; the highest set bit wins because it is visited last.
  always_comb begin
    lz = '0;
    for (int i = 0; i < int'(IW); i++) begin
      if (mag_q[i]) lz = 4'(IW - 1 - i);
    end
  end

  assign norm = mag_q << lz;
  assign addr = (idx_q | (8'd1 << b_q)) - 8'd1;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    m_d     = m_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    idx_d   = idx_q;
    b_d     = b_q;
    valid_d = valid_q;
    att_d   = att_q;
    ozero_d = ozero_q;
    osign_d = osign_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && rdy_q) begin
          mag_d   = lin_mag;
          sign_d  = lin_sign;
          state_d = StNorm;
        end
      end
      StNorm: begin
        m_d     = norm[IW-1 -: 13];
        exp_d   = lz;
        zero_d  = (mag_q == '0);
        idx_d   = '0;
        b_d     = 3'd7;
        state_d = StAddr;
      end
      StAddr: state_d = StCmp;
      StCmp: begin
        // t_q holds T[addr]; entries above m push the count up.
        if (t_q > m_q) idx_d = idx_q | (8'd1 << b_q);
        if (b_q == 3'd0) begin
          state_d = StDone;
        end else begin
          b_d     = b_q - 3'd1;
          state_d = StAddr;
        end
      end
      StDone: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          att_d   = zero_q ? 12'hfff : {exp_q, idx_q};
          ozero_d = zero_q;
          osign_d = sign_q;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      m_q     <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      att_q   <= '0;
      ozero_q <= 1'b0;
      osign_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else if (cen) begin
      state_q <= state_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      m_q     <= m_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      att_q   <= att_d;
      ozero_q <= ozero_d;
      osign_q <= osign_d;
      rdy_q   <= (state_d == StIdle);
    end
  end

  // Registered table read, ROM style without reset.
  always_ff @(posedge clk) begin
    if (cen) t_q <= TAB[13*addr +: 13];
  end

  assign in_ready  = rdy_q;
  assign out_valid = valid_q;
  assign att       = att_q;
  assign out_zero  = ozero_q;
  assign out_sign  = osign_q;

endmodule
